// File: rtl/bc_update_ctrl.sv
// bc_update_ctrl: frame-synchronous parameter controller for the
// brightness/contrast filter.
//
// A host posts contrast/brightness targets over a valid/ready handshake.
// The filter-facing outputs change only on the clock edge where vs_i is
// first sampled active (frame start), so a frame never sees mixed settings.
//
// Optional macro BC_UPDATE_CTRL_RAMP_EN:
//   defined   -> outputs move toward the targets by at most RAMP_STEP per
//                frame (RAMP state present).
//   undefined -> outputs jump to the targets on the first frame start after
//                accept; RAMP_STEP only feeds the parameter sanity check.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   cfg_contrast_i    target contrast (Q3.6 in bits [8:0])
//   cfg_brightness_i  target brightness (bits [7:0])
//   cfg_valid_i       target valid
//   cfg_ready_o       controller can accept a target
//   vs_i              vertical sync of the video stream
//   contrast_o        to filter contrast_i
//   brightness_o      to filter brightness_i
//   update_o          one-cycle pulse on each applied frame start
//   busy_o            target pending or ramp in progress
//
// Handshake: a transfer happens on a rising edge where cfg_valid_i and
// cfg_ready_o are both high. cfg_ready_o depends on state only; the host
// keeps cfg_* stable until the transfer, and valid while not ready is ignored.
//
// The FSM state is observable at the ports: cfg_ready_o = (state==IDLE) and
// busy_o = (state!=IDLE).
module bc_update_ctrl #(
  parameter logic [15:0] CONTRAST_RST   = 16'h0040,
  parameter logic [15:0] BRIGHTNESS_RST = 16'h0000,
  parameter logic [15:0] RAMP_STEP      = 16'd4,
  parameter logic        VS_ACTIVE      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cfg_contrast_i,
  input  logic [15:0] cfg_brightness_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic        vs_i,
  output logic [15:0] contrast_o,
  output logic [15:0] brightness_o,
  output logic        update_o,
  output logic        busy_o
);

  if (RAMP_STEP == 16'd0) begin : g_bad_ramp_step
    $error("bc_update_ctrl: RAMP_STEP must be >= 1");
  end

`ifdef BC_UPDATE_CTRL_RAMP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, RAMP = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;
`endif

  state_t      state_q, state_d;
  logic        vs_q;
  logic [15:0] contrast_q, contrast_d;
  logic [15:0] brightness_q, brightness_d;
  logic [15:0] tgt_c_q, tgt_c_d;
  logic [15:0] tgt_b_q, tgt_b_d;
  logic        update_q, update_d;
  logic        fs;
  logic        accept;

  // Leading edge of vs_i: one pulse however long vs_i stays active.
  assign fs     = (vs_i == VS_ACTIVE) && (vs_q != VS_ACTIVE);
  assign accept = cfg_valid_i && cfg_ready_o;

`ifdef BC_UPDATE_CTRL_RAMP_EN
  // One step toward tgt: snap when within RAMP_STEP, else move by RAMP_STEP.
  // The 17-bit distance keeps the comparison free of wrap.
  function automatic logic [15:0] step_toward(input logic [15:0] cur,
                                              input logic [15:0] tgt);
    logic [16:0] dist;
    logic        up;
    up   = (tgt >= cur);
    dist = up ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});
    if (dist <= {1'b0, RAMP_STEP}) begin
      return tgt;
    end else if (up) begin
      return cur + RAMP_STEP;
    end else begin
      return cur - RAMP_STEP;
    end
  endfunction

  logic [15:0] step_c, step_b;
  assign step_c = step_toward(contrast_q, tgt_c_q);
  assign step_b = step_toward(brightness_q, tgt_b_q);
`endif

  always_comb begin
    state_d      = state_q;
    contrast_d   = contrast_q;
    brightness_d = brightness_q;
    tgt_c_d      = tgt_c_q;
    tgt_b_d      = tgt_b_q;
    update_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // A frame start in the accept cycle is not used; the target waits
        // for the next one because application only happens from PEND.
        if (accept) begin
          tgt_c_d = cfg_contrast_i;
          tgt_b_d = cfg_brightness_i;
          state_d = PEND;
        end
      end
`ifdef BC_UPDATE_CTRL_RAMP_EN
      PEND, RAMP: begin
        if (fs) begin
          contrast_d   = step_c;
          brightness_d = step_b;
          update_d     = 1'b1;
          state_d      = ((step_c == tgt_c_q) && (step_b == tgt_b_q)) ? IDLE : RAMP;
        end
      end
`else
      PEND: begin
        if (fs) begin
          contrast_d   = tgt_c_q;
          brightness_d = tgt_b_q;
          update_d     = 1'b1;
          state_d      = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vs_q         <= ~VS_ACTIVE;
      contrast_q   <= CONTRAST_RST;
      brightness_q <= BRIGHTNESS_RST;
      tgt_c_q      <= CONTRAST_RST;
      tgt_b_q      <= BRIGHTNESS_RST;
      update_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= vs_i;
      contrast_q   <= contrast_d;
      brightness_q <= brightness_d;
      tgt_c_q      <= tgt_c_d;
      tgt_b_q      <= tgt_b_d;
      update_q     <= update_d;
    end
  end

  assign cfg_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign contrast_o   = contrast_q;
  assign brightness_o = brightness_q;
  assign update_o     = update_q;

endmodule

// File: tb/tb_bc_update_ctrl.sv
// Testbench for bc_update_ctrl: vector table, hand-written corner sequences
// and randomized traffic checked against a frame-level reference model.
module tb_bc_update_ctrl;

  localparam logic [15:0] C_RST = 16'h0040;
  localparam logic [15:0] B_RST = 16'h0000;
  localparam int          STEP  = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_contrast_i = '0;
  logic [15:0] cfg_brightness_i = '0;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_ready_o;
  logic        vs_i = 1'b0;
  logic [15:0] contrast_o;
  logic [15:0] brightness_o;
  logic        update_o;
  logic        busy_o;

  always #5 clk = ~clk;

  bc_update_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_contrast_i  (cfg_contrast_i),
    .cfg_brightness_i(cfg_brightness_i),
    .cfg_valid_i     (cfg_valid_i),
    .cfg_ready_o     (cfg_ready_o),
    .vs_i            (vs_i),
    .contrast_o      (contrast_o),
    .brightness_o    (brightness_o),
    .update_o        (update_o),
    .busy_o          (busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame-level view: a pending flag, a target, and the outputs that move
  // toward the target by bounded steps on each frame start.
  logic [15:0] m_c = C_RST, m_b = B_RST, m_tc = C_RST, m_tb = B_RST;
  bit          m_busy = 0, m_upd = 0, m_vs_prev = 0;
  logic [31:0] exp_q[$];

  function automatic logic [15:0] approach(input logic [15:0] cur, input logic [15:0] tgt);
`ifdef BC_UPDATE_CTRL_RAMP_EN
    int d;
    d = int'(tgt) - int'(cur);
    if (d > STEP) return cur + 16'(STEP);
    if (d < -STEP) return cur - 16'(STEP);
    return tgt;
`else
    return (cur == cur) ? tgt : tgt;
`endif
  endfunction

  task automatic model_edge();
    bit frame_start;
    if (rst) begin
      m_c = C_RST; m_b = B_RST; m_tc = C_RST; m_tb = B_RST;
      m_busy = 0; m_upd = 0; m_vs_prev = 0;
    end else begin
      frame_start = vs_i && !m_vs_prev;
      m_upd = 0;
      if (m_busy && frame_start) begin
        m_c = approach(m_c, m_tc);
        m_b = approach(m_b, m_tb);
        m_upd = 1;
        exp_q.push_back({m_c, m_b});
        if (m_c == m_tc && m_b == m_tb) m_busy = 0;
      end else if (!m_busy && cfg_valid_i) begin
        m_tc = cfg_contrast_i;
        m_tb = cfg_brightness_i;
        m_busy = 1;
      end
      m_vs_prev = vs_i;
    end
  endtask

  // ---------------- driver ----------------
  // Apply inputs, take one rising edge, advance the model, sample 1 ns later.
  task automatic tick(input logic r, input logic v, input logic [15:0] c,
                      input logic [15:0] b, input logic vs, input bit cmp_model);
    logic [31:0] e;
    rst = r; cfg_valid_i = v; cfg_contrast_i = c; cfg_brightness_i = b; vs_i = vs;
    @(posedge clk);
    model_edge();
    #1;
    if (update_o) begin
      if (exp_q.size() == 0) check("sb_unexpected_update", 32'(update_o), 32'd0);
      else begin
        e = exp_q.pop_front();
        check("sb_update_values", {contrast_o, brightness_o}, e);
      end
    end
    if (cmp_model) begin
      check("model_contrast", 32'(contrast_o), 32'(m_c));
      check("model_brightness", 32'(brightness_o), 32'(m_b));
      check("model_update", 32'(update_o), 32'(m_upd));
      check("model_busy", 32'(busy_o), 32'(m_busy));
      check("model_ready", 32'(cfg_ready_o), 32'(!m_busy));
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic r; logic v; logic [15:0] c; logic [15:0] b; logic vs;
    logic [15:0] ec; logic [15:0] eb; logic eu; logic ebz; logic erd;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic v, input logic [15:0] c, input logic [15:0] b,
                     input logic vs, input logic [15:0] ec, input logic [15:0] eb,
                     input logic eu, input logic ebz, input logic erd);
    vec_t x;
    x.r = r; x.v = v; x.c = c; x.b = b; x.vs = vs;
    x.ec = ec; x.eb = eb; x.eu = eu; x.ebz = ebz; x.erd = erd;
    tbl.push_back(x);
  endtask

  initial begin
    int pulses;
    bit h_valid;
    logic [15:0] h_c, h_b;
    int vs_cnt;
    logic vs_lvl;

    // Fill table:      r  v  c         b         vs  exp_c     exp_b     u  busy rdy
    add(1, 0, 16'h0, 16'h0, 0, C_RST, B_RST, 0, 0, 1);
    add(0, 0, 16'h0, 16'h0, 0, C_RST, B_RST, 0, 0, 1);
    add(0, 0, 16'h0, 16'h0, 1, C_RST, B_RST, 0, 0, 1);   // fs while idle
    add(0, 0, 16'h0, 16'h0, 0, C_RST, B_RST, 0, 0, 1);
`ifdef BC_UPDATE_CTRL_RAMP_EN
    add(0, 1, 16'h004A, 16'h0000, 0, 16'h0040, 16'h0000, 0, 1, 0);
    add(0, 0, 16'h0, 16'h0, 1, 16'h0044, 16'h0000, 1, 1, 0);
    add(0, 0, 16'h0, 16'h0, 0, 16'h0044, 16'h0000, 0, 1, 0);
    add(0, 0, 16'h0, 16'h0, 1, 16'h0048, 16'h0000, 1, 1, 0);
    add(0, 0, 16'h0, 16'h0, 0, 16'h0048, 16'h0000, 0, 1, 0);
    add(0, 0, 16'h0, 16'h0, 1, 16'h004A, 16'h0000, 1, 0, 1);
    add(0, 0, 16'h0, 16'h0, 0, 16'h004A, 16'h0000, 0, 0, 1);
    add(1, 0, 16'h0, 16'h0, 0, C_RST, B_RST, 0, 0, 1);
    add(0, 1, 16'h0039, 16'h0002, 0, 16'h0040, 16'h0000, 0, 1, 0);
    add(0, 0, 16'h0, 16'h0, 1, 16'h003C, 16'h0002, 1, 1, 0);
    add(0, 0, 16'h0, 16'h0, 0, 16'h003C, 16'h0002, 0, 1, 0);
    add(0, 0, 16'h0, 16'h0, 1, 16'h0039, 16'h0002, 1, 0, 1);
    add(0, 0, 16'h0, 16'h0, 0, 16'h0039, 16'h0002, 0, 0, 1);
    // accept coinciding with fs, target equal to outputs
    add(0, 1, 16'h0039, 16'h0002, 1, 16'h0039, 16'h0002, 0, 1, 0);
    add(0, 0, 16'h0, 16'h0, 1, 16'h0039, 16'h0002, 0, 1, 0);
    add(0, 0, 16'h0, 16'h0, 0, 16'h0039, 16'h0002, 0, 1, 0);
    add(0, 0, 16'h0, 16'h0, 1, 16'h0039, 16'h0002, 1, 0, 1);
`else
    add(0, 1, 16'h0080, 16'h0010, 0, C_RST, B_RST, 0, 1, 0);
    add(0, 0, 16'h0, 16'h0, 0, C_RST, B_RST, 0, 1, 0);
    add(0, 0, 16'h0, 16'h0, 1, 16'h0080, 16'h0010, 1, 0, 1);
    add(0, 0, 16'h0, 16'h0, 1, 16'h0080, 16'h0010, 0, 0, 1);
    add(0, 0, 16'h0, 16'h0, 0, 16'h0080, 16'h0010, 0, 0, 1);
    // accept coinciding with fs
    add(0, 1, 16'h0020, 16'h0005, 1, 16'h0080, 16'h0010, 0, 1, 0);
    add(0, 0, 16'h0, 16'h0, 1, 16'h0080, 16'h0010, 0, 1, 0);
    add(0, 0, 16'h0, 16'h0, 0, 16'h0080, 16'h0010, 0, 1, 0);
    add(0, 0, 16'h0, 16'h0, 1, 16'h0020, 16'h0005, 1, 0, 1);
    add(0, 0, 16'h0, 16'h0, 0, 16'h0020, 16'h0005, 0, 0, 1);
    // target equal to current outputs
    add(0, 1, 16'h0020, 16'h0005, 0, 16'h0020, 16'h0005, 0, 1, 0);
    add(0, 0, 16'h0, 16'h0, 1, 16'h0020, 16'h0005, 1, 0, 1);
    add(0, 0, 16'h0, 16'h0, 0, 16'h0020, 16'h0005, 0, 0, 1);
`endif

    foreach (tbl[i]) begin
      tick(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].b, tbl[i].vs, 0);
      check($sformatf("vec%0d_contrast", i), 32'(contrast_o), 32'(tbl[i].ec));
      check($sformatf("vec%0d_brightness", i), 32'(brightness_o), 32'(tbl[i].eb));
      check($sformatf("vec%0d_update", i), 32'(update_o), 32'(tbl[i].eu));
      check($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(tbl[i].ebz));
      check($sformatf("vec%0d_ready", i), 32'(cfg_ready_o), 32'(tbl[i].erd));
    end

    // Reset, no cfg, vs toggling: no update pulses, reset values held.
    tick(1, 0, 16'h0, 16'h0, 0, 1);
    pulses = 0;
    for (int f = 0; f < 10; f++) begin
      tick(0, 0, 16'h0, 16'h0, 1, 1); pulses += int'(update_o);
      tick(0, 0, 16'h0, 16'h0, 1, 1); pulses += int'(update_o);
      tick(0, 0, 16'h0, 16'h0, 0, 1); pulses += int'(update_o);
    end
    check("idle_no_update_pulses", 32'(pulses), 32'd0);
    check("idle_contrast_rst", 32'(contrast_o), 32'(C_RST));

    // vs held active for many cycles: exactly one application.
    tick(0, 1, 16'h0043, 16'h0002, 0, 1);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick(0, 0, 16'h0, 16'h0, 1, 1);
      pulses += int'(update_o);
    end
    check("long_vs_single_pulse", 32'(pulses), 32'd1);
    check("long_vs_contrast", 32'(contrast_o), 32'h0043);
    tick(0, 0, 16'h0, 16'h0, 0, 1);

    // Reset while a target is pending (mid-ramp in the ramp build).
    tick(0, 1, 16'h01FF, 16'h00FF, 0, 1);
`ifdef BC_UPDATE_CTRL_RAMP_EN
    tick(0, 0, 16'h0, 16'h0, 1, 1);
    tick(0, 0, 16'h0, 16'h0, 0, 1);
    check("mid_ramp_busy", 32'(busy_o), 32'd1);
`endif
    tick(1, 0, 16'h0, 16'h0, 0, 1);
    check("rst_mid_contrast", 32'(contrast_o), 32'(C_RST));
    check("rst_mid_brightness", 32'(brightness_o), 32'(B_RST));
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_ready", 32'(cfg_ready_o), 32'd1);
    tick(0, 0, 16'h0, 16'h0, 1, 1);
    check("rst_mid_no_update", 32'(update_o), 32'd0);
    check("rst_mid_contrast_hold", 32'(contrast_o), 32'(C_RST));
    tick(0, 0, 16'h0, 16'h0, 0, 1);

    // Randomized traffic; the host holds its data until accepted.
    h_valid = 0; h_c = '0; h_b = '0; vs_cnt = 3; vs_lvl = 0;
    for (int n = 0; n < 4000; n++) begin
      if (!h_valid && $urandom_range(0, 3) == 0) begin
        h_valid = 1;
        if ($urandom_range(0, 7) == 0) begin
          h_c = 16'($urandom()); h_b = 16'($urandom());
        end else begin
          h_c = 16'($urandom_range(0, 511)); h_b = 16'($urandom_range(0, 255));
        end
      end
      if (vs_cnt == 0) begin
        vs_lvl = ~vs_lvl;
        vs_cnt = vs_lvl ? $urandom_range(1, 4) : $urandom_range(1, 12);
      end
      vs_cnt--;
      begin
        bit acc;
        bit do_rst;
        acc = h_valid && cfg_ready_o;
        do_rst = ($urandom_range(0, 299) == 0);
        tick(do_rst, h_valid, h_c, h_b, vs_lvl, 1);
        if (acc && !do_rst) h_valid = 0;
      end
    end
    check("sb_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
